// File: rtl/uart_rx_cond_pkg.sv
// Shared constants and helpers for the UART RX line conditioner.
package uart_rx_cond_pkg;

    localparam logic        LINE_IDLE_LVL   = 1'b1;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_FILT_WD     = 4;
    localparam int unsigned DEF_BRK_WD      = 12;
    localparam int unsigned DEF_GCNT_WD     = 8;

    // Increment v, holding at the all-ones value of a wd-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned wd);
        logic [31:0] max_v;
        max_v = (wd >= 32) ? '1 : ((32'd1 << wd) - 32'd1);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/uart_rx_conditioner_sync.sv
// Multi-stage single-bit synchroniser; resets to the idle line level.
module rx_bit_sync
    import uart_rx_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{LINE_IDLE_LVL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_conditioner.sv
// RX line conditioner: synchroniser, stability filter, edge pulses,
// break/idle detection and saturating glitch counter.
module uart_rx_conditioner
    import uart_rx_cond_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned FILT_WD     = DEF_FILT_WD,
    parameter int unsigned BRK_WD      = DEF_BRK_WD,
    parameter int unsigned GCNT_WD     = DEF_GCNT_WD
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN_A,
    input  logic               EN,
    input  logic [FILT_WD-1:0] FILT_LEN,
    input  logic [BRK_WD-1:0]  BRK_LEN,
    input  logic [BRK_WD-1:0]  IDLE_LEN,
    input  logic               CLR_CNT,
    output logic               RX_OUT,
    output logic               FALL_PULSE,
    output logic               RISE_PULSE,
    output logic               BRK_DET,
    output logic               BRK_END,
    output logic               IDLE,
    output logic [GCNT_WD-1:0] GLITCH_CNT
);

    localparam logic [FILT_WD:0] FONE = 1;

    logic               s_sync;
    logic               rx_out_q,  rx_out_d;
    logic [FILT_WD-1:0] fcnt_q,    fcnt_d;
    logic [GCNT_WD-1:0] gcnt_q,    gcnt_d;
    logic [BRK_WD-1:0]  lcnt_q,    lcnt_d;
    logic [BRK_WD-1:0]  hcnt_q,    hcnt_d;
    logic               fall_q,    fall_d;
    logic               rise_q,    rise_d;
    logic               brk_det_q, brk_det_d;
    logic               brk_end_q, brk_end_d;
    logic               idle_q,    idle_d;
    logic [FILT_WD-1:0] eff;
    logic [FILT_WD:0]   fcnt_inc;
    logic               glitch_inc;

    rx_bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (CLK),
        .rst (RST),
        .d   (RX_IN_A),
        .q   (s_sync)
    );

    always_comb begin
        rx_out_d   = rx_out_q;
        fcnt_d     = fcnt_q;
        glitch_inc = 1'b0;
        eff        = (FILT_LEN == '0) ? FONE[FILT_WD-1:0] : FILT_LEN;
        fcnt_inc   = {1'b0, fcnt_q} + FONE;

        // Bypass keeps fcnt at zero, so an EN toggle always restarts the filter.
        if (!EN) begin
            rx_out_d = s_sync;
            fcnt_d   = '0;
        end else if (s_sync != rx_out_q) begin
            if (fcnt_inc >= {1'b0, eff}) begin
                rx_out_d = s_sync;
                fcnt_d   = '0;
            end else begin
                fcnt_d = fcnt_inc[FILT_WD-1:0];
            end
        end else begin
            fcnt_d     = '0;
            glitch_inc = (fcnt_q != '0);
        end

        if (CLR_CNT) begin
            gcnt_d = '0;
        end else if (glitch_inc) begin
            gcnt_d = GCNT_WD'(sat_inc(32'(gcnt_q), GCNT_WD));
        end else begin
            gcnt_d = gcnt_q;
        end

        lcnt_d = rx_out_d ? '0 : BRK_WD'(sat_inc(32'(lcnt_q), BRK_WD));
        hcnt_d = rx_out_d ? BRK_WD'(sat_inc(32'(hcnt_q), BRK_WD)) : '0;

        fall_d    = rx_out_q & ~rx_out_d;
        rise_d    = ~rx_out_q & rx_out_d;
        brk_det_d = ~rx_out_d & (brk_det_q | ((BRK_LEN != '0) && (lcnt_d >= BRK_LEN)));
        brk_end_d = brk_det_q & rx_out_d;
        idle_d    = rx_out_d & (idle_q | ((IDLE_LEN != '0) && (hcnt_d >= IDLE_LEN)));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_out_q  <= LINE_IDLE_LVL;
            fcnt_q    <= '0;
            gcnt_q    <= '0;
            lcnt_q    <= '0;
            hcnt_q    <= '0;
            fall_q    <= 1'b0;
            rise_q    <= 1'b0;
            brk_det_q <= 1'b0;
            brk_end_q <= 1'b0;
            idle_q    <= 1'b0;
        end else begin
            rx_out_q  <= rx_out_d;
            fcnt_q    <= fcnt_d;
            gcnt_q    <= gcnt_d;
            lcnt_q    <= lcnt_d;
            hcnt_q    <= hcnt_d;
            fall_q    <= fall_d;
            rise_q    <= rise_d;
            brk_det_q <= brk_det_d;
            brk_end_q <= brk_end_d;
            idle_q    <= idle_d;
        end
    end

    assign RX_OUT     = rx_out_q;
    assign FALL_PULSE = fall_q;
    assign RISE_PULSE = rise_q;
    assign BRK_DET    = brk_det_q;
    assign BRK_END    = brk_end_q;
    assign IDLE       = idle_q;
    assign GLITCH_CNT = gcnt_q;

endmodule

// File: doc/uart_rx_conditioner.md
Name: uart_rx_conditioner

Overview:
Front-end stage placed directly upstream of the UART receiver's serial input (RX_IN_S), in the UART_CLK/RX clock domain. It synchronises the raw asynchronous RX pin and removes glitches with a programmable stability filter. It also detects line break and line idle conditions, and produces one-cycle edge pulses. The filtered bit RX_OUT replaces the raw pin at the UART receiver input.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the input synchroniser chain (minimum 2).
FILT_WD, 4, width of FILT_LEN and of the filter counter.
BRK_WD, 12, width of BRK_LEN, IDLE_LEN and the low/high run counters.
GCNT_WD, 8, width of the saturating glitch counter.

Ports:
CLK  in  1  block clock.
RST  in  1  asynchronous reset, active-high.
RX_IN_A  in  1  raw asynchronous serial line; idle level is 1.
EN  in  1  1 = filter active; 0 = filter bypassed.
FILT_LEN  in  FILT_WD  consecutive differing samples required to change RX_OUT; 0 is treated as 1.
BRK_LEN  in  BRK_WD  low-run length that flags a break; 0 disables break detection.
IDLE_LEN  in  BRK_WD  high-run length that flags idle; 0 disables idle detection.
CLR_CNT  in  1  synchronous clear of GLITCH_CNT.
RX_OUT  out  1  filtered serial bit, fed to the UART receiver.
FALL_PULSE  out  1  one-cycle pulse when RX_OUT goes 1->0.
RISE_PULSE  out  1  one-cycle pulse when RX_OUT goes 0->1.
BRK_DET  out  1  level, asserted while a break is in progress.
BRK_END  out  1  one-cycle pulse when a break terminates.
IDLE  out  1  level, asserted while the line is idle.
GLITCH_CNT  out  GCNT_WD  count of rejected glitches, saturating.

Behaviour:
- Reset (asynchronous, RST=1):
  - Synchroniser stages = 1, RX_OUT = 1.
  - FALL_PULSE, RISE_PULSE, BRK_DET, BRK_END and IDLE = 0.
  - GLITCH_CNT = 0; all internal counters = 0.
  - Applies immediately, including mid-filter or mid-break; no pulse is generated on reset entry or exit.
- Synchroniser: s_sync is the last stage of the chain. It is not consumed anywhere other than the filter.
- Filter (EN=1), with eff = max(FILT_LEN,1):
  - If s_sync == RX_OUT: fcnt is cleared. If fcnt was nonzero, the sample sequence is a rejected glitch and GLITCH_CNT increments.
  - If s_sync != RX_OUT: fcnt increments. On the edge where fcnt+1 >= eff, RX_OUT <= s_sync and fcnt <= 0.
  - Latency from a stable RX_IN_A change to the RX_OUT change is SYNC_STAGES + eff clock edges.
  - A FILT_LEN change takes effect on the next sample. If fcnt already meets the new length, the next differing sample commits.
- Bypass (EN=0):
  - RX_OUT <= s_sync every cycle; fcnt is held at 0; no glitch counting.
  - Edge, break and idle logic still operate.
  - On an EN toggle, fcnt is cleared.
- Edge pulses: FALL_PULSE/RISE_PULSE are high exactly in the first cycle RX_OUT shows the new value. They are never both high together.
- Break:
  - lcnt counts cycles with RX_OUT=0, saturating at all-ones, and clears when RX_OUT=1.
  - BRK_DET sets in the cycle lcnt reaches BRK_LEN and holds until RX_OUT returns to 1.
  - BRK_END pulses in the first cycle RX_OUT=1 after BRK_DET; BRK_DET clears in that same cycle.
- Idle:
  - hcnt counts cycles with RX_OUT=1, saturating, and clears when RX_OUT=0.
  - IDLE sets when hcnt reaches IDLE_LEN and clears in the first cycle RX_OUT=0.
  - After reset, IDLE sets IDLE_LEN cycles later if the line stays high.
- GLITCH_CNT: saturates at 2^GCNT_WD-1. CLR_CNT wins over a simultaneous increment.

Decomposition:
- Package uart_rx_cond_pkg holds:
  - LINE_IDLE_LVL = 1
  - the default widths for SYNC_STAGES, FILT_WD, BRK_WD and GCNT_WD
  - a saturating-increment function, shared by lcnt, hcnt and GLITCH_CNT.
- One sub-module, rx_bit_sync: a SYNC_STAGES-deep single-bit synchroniser with reset value 1.

Test Plan:
- EN=1, FILT_LEN=4: drive RX_IN_A low and hold -> RX_OUT falls 6 edges later, FALL_PULSE high for 1 cycle, GLITCH_CNT=0.
- EN=1, FILT_LEN=4: drive a 2-cycle low glitch, then high -> RX_OUT stays 1, no pulses, GLITCH_CNT=1. Repeat 300 times -> GLITCH_CNT=255; assert CLR_CNT -> 0.
- EN=0: drive a 1-cycle low glitch -> RX_OUT low for 1 cycle after 3 edges, FALL_PULSE then RISE_PULSE, GLITCH_CNT=0.
- BRK_LEN=100, FILT_LEN=1: hold line low 150 cycles -> BRK_DET rises after RX_OUT has been low 100 cycles. Release -> BRK_END pulses once and BRK_DET clears in the same cycle.
- IDLE_LEN=20: after reset with the line high -> IDLE=1 at cycle 20. Drive a valid start bit -> IDLE=0 in the cycle FALL_PULSE=1.
- Assert RST mid-break and mid-filter count -> all outputs return to reset values immediately. After release, a low line needs the full FILT_LEN again.
